// File: rtl/lab3_mem_line_pkg.sv
// Shared types and sizes for the cache-line to memory-word adapter.
package lab3_mem_line_pkg;

    localparam int WORD_W         = 32;
    localparam int LINE_W         = 128;
    localparam int WORDS_PER_LINE = 4;

    localparam logic [3:0] TYPE_READ  = 4'd0;
    localparam logic [3:0] TYPE_WRITE = 4'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/lab3_mem_line_collector.sv
// Four word slots written by index and read back as one flat line (slot 0 in the low bits).
module lab3_mem_line_collector
    import lab3_mem_line_pkg::*;
(
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [1:0]        wr_idx_i,
    input  logic [WORD_W-1:0] wr_data_i,
    output logic [LINE_W-1:0] rd_data_o
);

    genvar gi;
    generate
        for (gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_slot
            logic [WORD_W-1:0] slot_q;

            // Slots are plain storage; every transaction overwrites all four before use.
            always_ff @(posedge clk) begin
                if (wr_en_i && (wr_idx_i == 2'(gi))) begin
                    slot_q <= wr_data_i;
                end
            end

            assign rd_data_o[gi*WORD_W +: WORD_W] = slot_q;
        end
    endgenerate

endmodule

// File: rtl/lab3_mem_line_adapter.sv
// Splits 16-byte line requests into four 4-byte memory requests and merges the
// word responses (possibly out of order) back into one line response.
module lab3_mem_line_adapter
    import lab3_mem_line_pkg::*;
(
    input  logic              clk,
    input  logic              reset,

    input  logic              linereq_val,
    output logic              linereq_rdy,
    input  logic [3:0]        linereq_type,
    input  logic [7:0]        linereq_opaque,
    input  logic [31:0]       linereq_addr,
    input  logic [LINE_W-1:0] linereq_data,

    output logic              lineresp_val,
    input  logic              lineresp_rdy,
    output logic [3:0]        lineresp_type,
    output logic [7:0]        lineresp_opaque,
    output logic [LINE_W-1:0] lineresp_data,

    output logic              memreq_val,
    input  logic              memreq_rdy,
    output logic [3:0]        memreq_type,
    output logic [7:0]        memreq_opaque,
    output logic [31:0]       memreq_addr,
    output logic [1:0]        memreq_len,
    output logic [31:0]       memreq_data,

    input  logic              memresp_val,
    output logic              memresp_rdy,
    input  logic [3:0]        memresp_type,
    input  logic [7:0]        memresp_opaque,
    input  logic [31:0]       memresp_data
);

    state_t            state_q, state_d;
    logic [3:0]        type_q;
    logic [7:0]        opaque_q;
    logic [27:0]       line_addr_q;
    logic [LINE_W-1:0] line_data_q;
    logic [1:0]        issue_cnt_q;
    logic              issue_done_q;
    logic [1:0]        recv_cnt_q;
    logic              recv_done_q;

    logic              line_fire;
    logic              req_fire;
    logic              resp_fire;
    logic              is_write;
    logic [LINE_W-1:0] slot_line;
    logic              unused_ok;

    assign line_fire = linereq_val & linereq_rdy;
    assign req_fire  = memreq_val & memreq_rdy;
    assign resp_fire = memresp_val & memresp_rdy;
    assign is_write  = (type_q == TYPE_WRITE);

    // Response type and the high opaque bits carry nothing we need; the slot comes from opaque[1:0].
    assign unused_ok = ^{memresp_type, memresp_opaque[7:2], linereq_addr[3:0]};

    always_comb begin
        state_d      = state_q;
        linereq_rdy  = 1'b0;
        memreq_val   = 1'b0;
        memresp_rdy  = 1'b0;
        lineresp_val = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Gated by reset so the ready is low for the whole time reset is held.
                linereq_rdy = reset;
                if (linereq_val && reset) begin
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                memreq_val  = ~issue_done_q;
                memresp_rdy = ~recv_done_q;
                if (resp_fire && (recv_cnt_q == 2'd3)) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                lineresp_val = 1'b1;
                if (lineresp_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            type_q       <= 4'd0;
            opaque_q     <= 8'd0;
            line_addr_q  <= 28'd0;
            line_data_q  <= '0;
            issue_cnt_q  <= 2'd0;
            issue_done_q <= 1'b0;
            recv_cnt_q   <= 2'd0;
            recv_done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (line_fire) begin
                type_q       <= linereq_type;
                opaque_q     <= linereq_opaque;
                line_addr_q  <= linereq_addr[31:4];
                line_data_q  <= linereq_data;
                issue_cnt_q  <= 2'd0;
                issue_done_q <= 1'b0;
                recv_cnt_q   <= 2'd0;
                recv_done_q  <= 1'b0;
            end
            if (req_fire) begin
                issue_cnt_q  <= issue_cnt_q + 2'd1;
                issue_done_q <= issue_done_q | (issue_cnt_q == 2'd3);
            end
            if (resp_fire) begin
                recv_cnt_q  <= recv_cnt_q + 2'd1;
                recv_done_q <= recv_done_q | (recv_cnt_q == 2'd3);
            end
        end
    end

    lab3_mem_line_collector u_collector (
        .clk       (clk),
        .wr_en_i   (resp_fire),
        .wr_idx_i  (memresp_opaque[1:0]),
        .wr_data_i (memresp_data),
        .rd_data_o (slot_line)
    );

    // Word index doubles as the request opaque so responses find their slot in any order.
    assign memreq_type   = type_q;
    assign memreq_opaque = {6'b0, issue_cnt_q};
    assign memreq_addr   = {line_addr_q, issue_cnt_q, 2'b00};
    assign memreq_len    = 2'd0;
    assign memreq_data   = is_write ? line_data_q[{issue_cnt_q, 5'd0} +: WORD_W] : 32'd0;

    assign lineresp_type   = type_q;
    assign lineresp_opaque = opaque_q;
    assign lineresp_data   = is_write ? '0 : slot_line;

endmodule

// File: tb/tb_lab3_mem_line_adapter.sv
// Randomised scoreboard bench for lab3_mem_line_adapter with a behavioural memory and line model.
module tb_lab3_mem_line_adapter;
    import lab3_mem_line_pkg::*;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         linereq_val = 1'b0, linereq_rdy;
    logic [3:0]   linereq_type = 4'd0;
    logic [7:0]   linereq_opaque = 8'd0;
    logic [31:0]  linereq_addr = 32'd0;
    logic [127:0] linereq_data = '0;
    logic         lineresp_val, lineresp_rdy = 1'b0;
    logic [3:0]   lineresp_type;
    logic [7:0]   lineresp_opaque;
    logic [127:0] lineresp_data;
    logic         memreq_val, memreq_rdy = 1'b0;
    logic [3:0]   memreq_type;
    logic [7:0]   memreq_opaque;
    logic [31:0]  memreq_addr;
    logic [1:0]   memreq_len;
    logic [31:0]  memreq_data;
    logic         memresp_val = 1'b0, memresp_rdy;
    logic [3:0]   memresp_type = 4'd0;
    logic [7:0]   memresp_opaque = 8'd0;
    logic [31:0]  memresp_data = 32'd0;

    always #5 clk = ~clk;

    lab3_mem_line_adapter dut (
        .clk(clk), .reset(reset),
        .linereq_val(linereq_val), .linereq_rdy(linereq_rdy), .linereq_type(linereq_type),
        .linereq_opaque(linereq_opaque), .linereq_addr(linereq_addr), .linereq_data(linereq_data),
        .lineresp_val(lineresp_val), .lineresp_rdy(lineresp_rdy), .lineresp_type(lineresp_type),
        .lineresp_opaque(lineresp_opaque), .lineresp_data(lineresp_data),
        .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_type(memreq_type),
        .memreq_opaque(memreq_opaque), .memreq_addr(memreq_addr), .memreq_len(memreq_len),
        .memreq_data(memreq_data),
        .memresp_val(memresp_val), .memresp_rdy(memresp_rdy), .memresp_type(memresp_type),
        .memresp_opaque(memresp_opaque), .memresp_data(memresp_data)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] addr; logic [7:0] opq; logic [3:0] typ; logic [31:0] data; } wreq_t;
    typedef struct { logic [3:0] typ; logic [7:0] opq; logic [127:0] data; } lresp_t;
    typedef struct { logic [7:0] opq; logic [31:0] data; } mresp_t;

    wreq_t       exp_word_q[$];
    lresp_t      exp_line_q[$];
    mresp_t      pend_q[$];
    logic [31:0] mem     [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    // Knobs written by the main sequence only while the adapter is idle.
    int mem_rdy_mode = 0;   // 0 always ready, 1 toggle, 2 random
    int resp_mode = 0;      // 0 in order next cycle, 1 random order/delay, 2 fixed order 2,0,3,1
    int sink_mode = 0;      // 0 always ready, 1 random, 2 hold low 3 valid cycles
    int ooo_seq [4] = '{2, 0, 3, 1};

    bit busy = 0, lat_check_en = 0, b2b_check_en = 0, resp_seen = 0;
    int hs_cyc = 0, last_resp_cyc = -100, words_line = 0;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : init_word(a);
    endfunction
    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Line-level reference: four word requests and the merged line the cache should see.
    task automatic model_line(input logic [3:0] t, input logic [7:0] o, input logic [31:0] a,
                              input logic [127:0] d);
        logic [31:0] base;
        wreq_t w;
        lresp_t lr;
        base = a & 32'hFFFF_FFF0;
        lr.typ = t; lr.opq = o; lr.data = '0;
        for (int i = 0; i < 4; i++) begin
            w.addr = base + 32'(4 * i);
            w.opq  = 8'(i);
            w.typ  = t;
            w.data = (t == TYPE_WRITE) ? d[32*i +: 32] : 32'h0;
            exp_word_q.push_back(w);
            if (t == TYPE_WRITE) ref_mem[w.addr] = d[32*i +: 32];
            else if (t == TYPE_READ) lr.data[32*i +: 32] = ref_rd(w.addr);
        end
        exp_line_q.push_back(lr);
    endtask

    // Monitor / scoreboard
    initial begin
        wreq_t w;
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("reset_outputs", 128'({linereq_rdy, lineresp_val, memreq_val, memresp_rdy}), 128'(0));
                exp_word_q.delete();
                exp_line_q.delete();
                busy = 0;
                words_line = 0;
            end else begin
                if (!busy)
                    chk("idle_outputs", 128'({linereq_rdy, lineresp_val, memreq_val, memresp_rdy}), 128'(4'b1000));
                else
                    chk("busy_linereq_rdy", 128'(linereq_rdy), 128'(0));
                if (lineresp_val)
                    chk("resp_state_mem_idle", 128'({memreq_val, memresp_rdy}), 128'(0));
                if (memreq_val && memreq_rdy) begin
                    if (exp_word_q.size() == 0) begin
                        chk("unexpected_word_req", 128'(memreq_addr), 128'hFFFF_FFFF_FFFF);
                    end else begin
                        w = exp_word_q.pop_front();
                        chk("word_req", 128'({memreq_addr, memreq_opaque, memreq_type, memreq_data, memreq_len}),
                            128'({w.addr, w.opq, w.typ, w.data, 2'b00}));
                        if (lat_check_en)
                            chk("word_issue_cycle", 128'(cyc - hs_cyc), 128'(1 + words_line));
                    end
                    words_line++;
                end
                if (lineresp_val) begin
                    if (lat_check_en && !resp_seen)
                        chk("lineresp_latency", 128'(cyc - hs_cyc), 128'(6));
                    resp_seen = 1;
                    if (exp_line_q.size() == 0) begin
                        chk("unexpected_lineresp", 128'(lineresp_opaque), 128'h1_0000);
                    end else begin
                        chk("lineresp_type_opq", 128'({lineresp_type, lineresp_opaque}),
                            128'({exp_line_q[0].typ, exp_line_q[0].opq}));
                        chk("lineresp_data", lineresp_data, exp_line_q[0].data);
                    end
                    if (lineresp_rdy) begin
                        chk("words_per_line", 128'(words_line), 128'(4));
                        $display("txn type=%0d opq=%02h data=%h done at cycle %0d",
                                 lineresp_type, lineresp_opaque, lineresp_data, cyc);
                        if (exp_line_q.size() != 0) void'(exp_line_q.pop_front());
                        busy = 0;
                        last_resp_cyc = cyc;
                    end
                end
                if (linereq_val && linereq_rdy) begin
                    if (b2b_check_en) begin
                        chk("back_to_back_accept", 128'(cyc), 128'(last_resp_cyc + 1));
                        b2b_check_en = 0;
                    end
                    model_line(linereq_type, linereq_opaque, linereq_addr, linereq_data);
                    busy = 1;
                    hs_cyc = cyc;
                    words_line = 0;
                    resp_seen = 0;
                end
            end
        end
    end

    // Behavioural word memory: sample handshakes at negedge, drive after the next posedge.
    initial begin
        mresp_t r;
        bit presenting = 0;
        int present_idx = 0;
        int ooo_idx = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                pend_q.delete();
                presenting = 0;
                ooo_idx = 0;
            end else begin
                if (presenting && memresp_val && memresp_rdy) begin
                    pend_q.delete(present_idx);
                    presenting = 0;
                    if (resp_mode == 2) ooo_idx = (ooo_idx + 1) % 4;
                end
                if (memreq_val && memreq_rdy) begin
                    r.opq = memreq_opaque;
                    if (memreq_type == TYPE_WRITE) begin
                        mem[memreq_addr] = memreq_data;
                        r.data = $urandom;
                    end else begin
                        r.data = mem_rd(memreq_addr);
                    end
                    pend_q.push_back(r);
                end
            end
            @(posedge clk);
            #1;
            if (!presenting && pend_q.size() > 0) begin
                case (resp_mode)
                    0: begin present_idx = 0; presenting = 1; end
                    1: if ($urandom_range(0, 3) != 0) begin
                           present_idx = int'($urandom_range(0, pend_q.size() - 1));
                           presenting = 1;
                       end
                    default: if (pend_q.size() == 4 || ooo_idx != 0) begin
                        for (int k = 0; k < pend_q.size(); k++) begin
                            if (!presenting && pend_q[k].opq[1:0] == 2'(ooo_seq[ooo_idx])) begin
                                present_idx = k;
                                presenting = 1;
                            end
                        end
                    end
                endcase
            end
            memresp_val    = presenting;
            memresp_opaque = presenting ? pend_q[present_idx].opq : 8'($urandom);
            memresp_data   = presenting ? pend_q[present_idx].data : $urandom;
            memresp_type   = 4'($urandom);
            case (mem_rdy_mode)
                0:       memreq_rdy = 1'b1;
                1:       memreq_rdy = ~memreq_rdy;
                default: memreq_rdy = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Line response sink
    initial begin
        int held = 0;
        forever begin
            @(negedge clk);
            if (lineresp_val && !lineresp_rdy) held++;
            else held = 0;
            @(posedge clk);
            #1;
            case (sink_mode)
                0:       lineresp_rdy = 1'b1;
                1:       lineresp_rdy = 1'($urandom_range(0, 1));
                default: lineresp_rdy = (held >= 3);
            endcase
        end
    end

    // Called at posedge+1; returns at posedge+1 after the request handshake.
    task automatic send_line(input logic [3:0] t, input logic [31:0] a, input logic [127:0] d,
                             input logic [7:0] o);
        bit ok;
        ok = 0;
        linereq_type = t; linereq_addr = a; linereq_data = d; linereq_opaque = o;
        linereq_val = 1'b1;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge clk);
            ok = linereq_rdy;
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL linereq_accept_timeout actual=not_accepted required=accepted addr=%h", a);
        end
        @(posedge clk);
        #1;
        linereq_val = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int n = 0; n < 400 && !ok; n++) begin
            @(negedge clk);
            ok = !busy && (exp_line_q.size() == 0);
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL line_complete_timeout actual=busy required=idle pending=%0d", exp_line_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Read refill with minimum latency
        for (int i = 0; i < 4; i++) begin
            mem[32'h1230 + 32'(4 * i)]     = 32'hA0 + 32'(i);
            ref_mem[32'h1230 + 32'(4 * i)] = 32'hA0 + 32'(i);
        end
        lat_check_en = 1;
        send_line(TYPE_READ, 32'h0000_1230, '0, 8'h11);
        wait_idle();
        lat_check_en = 0;

        // Evict write
        send_line(TYPE_WRITE, 32'h0000_4560, {32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000}, 8'h22);
        wait_idle();

        // Out-of-order responses
        resp_mode = 2;
        send_line(TYPE_READ, 32'h0000_4560, '0, 8'h33);
        wait_idle();
        resp_mode = 0;

        // Backpressure on both sides, with a second request waiting
        mem_rdy_mode = 1;
        sink_mode = 2;
        send_line(TYPE_READ, 32'h0000_1230, '0, 8'h44);
        send_line(TYPE_WRITE, 32'h0000_5000, {4{32'h1357_9BDF}}, 8'h45);
        wait_idle();
        mem_rdy_mode = 0;
        sink_mode = 0;

        // Reset after two of four words issued
        send_line(TYPE_READ, 32'h0000_2000, '0, 8'h55);
        ok = 0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(posedge clk);
            #1;
            ok = (words_line >= 2);
        end
        chk("two_words_before_reset", 128'(ok), 128'(1));
        reset = 1'b0;
        #1;
        chk("reset_vals_immediate", 128'({linereq_rdy, lineresp_val, memreq_val, memresp_rdy}), 128'(0));
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem[32'h2000 + 32'(4 * i)]     = 32'hF00D_0000 + 32'(i);
            ref_mem[32'h2000 + 32'(4 * i)] = 32'hF00D_0000 + 32'(i);
        end
        send_line(TYPE_READ, 32'h0000_2000, '0, 8'h56);
        wait_idle();

        // Back-to-back reads
        send_line(TYPE_READ, 32'h0000_1230, '0, 8'h66);
        b2b_check_en = 1;
        send_line(TYPE_READ, 32'h0000_2000, '0, 8'h67);
        wait_idle();
        chk("b2b_check_consumed", 128'(b2b_check_en), 128'(0));

        // Random traffic
        for (int it = 0; it < 48; it++) begin
            if (it % 8 == 0) begin
                wait_idle();
                mem_rdy_mode = int'($urandom_range(0, 2));
                resp_mode    = int'($urandom_range(0, 1));
                sink_mode    = int'($urandom_range(0, 1));
            end
            send_line(4'($urandom_range(0, 1)),
                      32'h0000_8000 + 32'($urandom_range(0, 7) * 16) + 32'($urandom_range(0, 15)),
                      {$urandom, $urandom, $urandom, $urandom}, 8'($urandom));
        end
        wait_idle();

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
